// File: rtl/fp_mult_ctrl.sv
// fp_mult_ctrl -- sequencer and two-requester round-robin arbiter in front of
// the shared single-precision multiplier datapath.
//
// One operation is in flight at a time. The controller works through these steps:
//   1. It accepts a request from one of the two issue ports.
//   2. It registers the operands and the rounding mode towards the datapath.
//   3. It steps the datapath through MULT (MULT_CYCLES cycles), then NORM,
//      ROUND and EXC (one cycle each).
//   4. It captures the result and status on the EXC->RESP edge.
//   5. It holds the response until the owning requester takes it.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   req_valid/req_ready[1:0] request handshake, bit i = requester i
//   req_a0/b0/rnd0           requester 0 operands and rounding mode
//   req_a1/b1/rnd1           requester 1 operands and rounding mode
//   dp_a/dp_b/dp_rnd         registered operands/mode driven to the datapath
//   mult/norm/round/exc_en   one-hot stage enables
//   dp_result/dp_status      datapath outputs, sampled in EXC
//   resp_valid/resp_ready    response handshake, bit = owning requester
//   resp_result/resp_status  registered response; status[7] = mode coerced
//   busy                     high whenever not IDLE
//   op_count                 completed operations, wraps at 16 bits
module fp_mult_ctrl #(
  parameter int MULT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [2:0]  req_rnd0,
  input  logic [2:0]  req_rnd1,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic [2:0]  dp_rnd,
  output logic        mult_en,
  output logic        norm_en,
  output logic        round_en,
  output logic        exc_en,
  input  logic [31:0] dp_result,
  input  logic [7:0]  dp_status,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_result,
  output logic [7:0]  resp_status,
  output logic        busy,
  output logic [15:0] op_count
);

  if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
    $error("fp_mult_ctrl: MULT_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(MULT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    EXC   = 3'd4,
    RESP  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, last_grant_q, illegal_q;
  logic [31:0] dp_a_q, dp_b_q, resp_result_q;
  logic [2:0]  dp_rnd_q;
  logic [7:0]  resp_status_q;
  logic [15:0] op_count_q;
  logic [1:0]  resp_valid_q;
  logic        mult_en_q, norm_en_q, round_en_q, exc_en_q, busy_q;

  logic        grant, accept, resp_hs, rnd_bad;
  logic [2:0]  rnd_sel;

  // Bit 7 of the datapath status is replaced by the coercion flag.
  logic        unused_dp_status7;
  assign unused_dp_status7 = dp_status[7];

  // A lone requester wins outright; on a tie the one not served last wins.
  assign grant   = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
  assign accept  = (state_q == IDLE) && (|req_valid);
  assign resp_hs = (state_q == RESP) && resp_ready[owner_q];
  assign rnd_sel = grant ? req_rnd1 : req_rnd0;
  assign rnd_bad = (rnd_sel > 3'd5);

  // Gated with rst so nothing appears accepted while reset is held.
  assign req_ready = (rst && accept) ? (grant ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (accept) begin
               state_d = MULT;
               cnt_d   = CNT_LOAD;
             end
      MULT:  if (cnt_q == 4'd0) state_d = NORM;
             else               cnt_d   = cnt_q - 4'd1;
      NORM:  state_d = ROUND;
      ROUND: state_d = EXC;
      EXC:   state_d = RESP;
      RESP:  if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Enables, busy and resp_valid are registered from the next state so every
  // output comes straight off a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      illegal_q     <= 1'b0;
      dp_a_q        <= 32'd0;
      dp_b_q        <= 32'd0;
      dp_rnd_q      <= 3'd0;
      resp_result_q <= 32'd0;
      resp_status_q <= 8'd0;
      op_count_q    <= 16'd0;
      resp_valid_q  <= 2'b00;
      mult_en_q     <= 1'b0;
      norm_en_q     <= 1'b0;
      round_en_q    <= 1'b0;
      exc_en_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mult_en_q    <= (state_d == MULT);
      norm_en_q    <= (state_d == NORM);
      round_en_q   <= (state_d == ROUND);
      exc_en_q     <= (state_d == EXC);
      busy_q       <= (state_d != IDLE);
      // RESP is only entered from EXC, long after owner_q was latched.
      resp_valid_q <= (state_d == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
      if (accept) begin
        owner_q      <= grant;
        last_grant_q <= grant;
        dp_a_q       <= grant ? req_a1 : req_a0;
        dp_b_q       <= grant ? req_b1 : req_b0;
        dp_rnd_q     <= rnd_bad ? 3'd0 : rnd_sel;
        illegal_q    <= rnd_bad;
      end
      if (state_q == EXC) begin
        resp_result_q <= dp_result;
        resp_status_q <= {illegal_q, dp_status[6:0]};
      end
      if (resp_hs) op_count_q <= op_count_q + 16'd1;
    end
  end

  assign dp_a        = dp_a_q;
  assign dp_b        = dp_b_q;
  assign dp_rnd      = dp_rnd_q;
  assign mult_en     = mult_en_q;
  assign norm_en     = norm_en_q;
  assign round_en    = round_en_q;
  assign exc_en      = exc_en_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_status = resp_status_q;
  assign busy        = busy_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_fp_mult_ctrl.sv
// Bench for fp_mult_ctrl. Two instances: A (MULT_CYCLES=2) and B
// (MULT_CYCLES=1). 'sel' routes the shared stimulus to one of them and
// selects which one is observed. Each instance has a datapath stub: a
// truncating multiply, valid only while exc_en is high, and inverted junk
// otherwise. Expected values come from a transaction-level model: grant
// rule, latency from MULT_CYCLES, and per-instance op counts.
module tb_fp_mult_ctrl;

  logic        clk, rst, sel;
  logic [1:0]  req_valid, resp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_rnd0, req_rnd1;

  int n_err = 0;
  int n_chk = 0;

  // Truncating single-precision multiply for normal inputs.
  function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  // Instance A
  logic [1:0]  rr_a, rv_a;
  logic [31:0] dpa_a, dpb_a, res_a, dpres_a;
  logic [2:0]  dprnd_a;
  logic [7:0]  st_a, dpst_a;
  logic        men_a, nen_a, ren_a, een_a, busy_a;
  logic [15:0] cnt_a;
  assign dpres_a = een_a ? fake_mul(dpa_a, dpb_a) : ~fake_mul(dpa_a, dpb_a);
  assign dpst_a  = een_a ? {1'b1, 4'b0000, dprnd_a} : 8'h7F;

  fp_mult_ctrl #(.MULT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(sel ? 2'b00 : req_valid), .req_ready(rr_a),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_rnd0(req_rnd0), .req_rnd1(req_rnd1),
    .dp_a(dpa_a), .dp_b(dpb_a), .dp_rnd(dprnd_a),
    .mult_en(men_a), .norm_en(nen_a), .round_en(ren_a), .exc_en(een_a),
    .dp_result(dpres_a), .dp_status(dpst_a),
    .resp_valid(rv_a), .resp_ready(sel ? 2'b00 : resp_ready),
    .resp_result(res_a), .resp_status(st_a), .busy(busy_a), .op_count(cnt_a)
  );

  // Instance B
  logic [1:0]  rr_b, rv_b;
  logic [31:0] dpa_b, dpb_b, res_b, dpres_b;
  logic [2:0]  dprnd_b;
  logic [7:0]  st_b, dpst_b;
  logic        men_b, nen_b, ren_b, een_b, busy_b;
  logic [15:0] cnt_b;
  assign dpres_b = een_b ? fake_mul(dpa_b, dpb_b) : ~fake_mul(dpa_b, dpb_b);
  assign dpst_b  = een_b ? {1'b1, 4'b0000, dprnd_b} : 8'h7F;

  fp_mult_ctrl #(.MULT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(sel ? req_valid : 2'b00), .req_ready(rr_b),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_rnd0(req_rnd0), .req_rnd1(req_rnd1),
    .dp_a(dpa_b), .dp_b(dpb_b), .dp_rnd(dprnd_b),
    .mult_en(men_b), .norm_en(nen_b), .round_en(ren_b), .exc_en(een_b),
    .dp_result(dpres_b), .dp_status(dpst_b),
    .resp_valid(rv_b), .resp_ready(sel ? resp_ready : 2'b00),
    .resp_result(res_b), .resp_status(st_b), .busy(busy_b), .op_count(cnt_b)
  );

  // Observed (selected) instance
  logic [1:0]  o_rr, o_rv;
  logic [31:0] o_dpa, o_dpb, o_res;
  logic [2:0]  o_dprnd;
  logic [7:0]  o_st;
  logic        o_men, o_nen, o_ren, o_een, o_busy;
  logic [15:0] o_cnt;
  assign o_rr    = sel ? rr_b    : rr_a;
  assign o_rv    = sel ? rv_b    : rv_a;
  assign o_dpa   = sel ? dpa_b   : dpa_a;
  assign o_dpb   = sel ? dpb_b   : dpb_a;
  assign o_res   = sel ? res_b   : res_a;
  assign o_dprnd = sel ? dprnd_b : dprnd_a;
  assign o_st    = sel ? st_b    : st_a;
  assign o_men   = sel ? men_b   : men_a;
  assign o_nen   = sel ? nen_b   : nen_a;
  assign o_ren   = sel ? ren_b   : ren_a;
  assign o_een   = sel ? een_b   : een_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_cnt   = sel ? cnt_b   : cnt_a;

  logic [131:0] all_o;
  assign all_o = {o_rr, o_dpa, o_dpb, o_dprnd, o_men, o_nen, o_ren, o_een,
                  o_rv, o_res, o_st, o_busy, o_cnt};

  // Model state, per instance
  logic [15:0] m_cnt [2];
  logic        m_lastg [2];
  logic [31:0] m_lda;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one operation end to end. Entered just after a rising edge with the
  // selected instance idle. Leaves just after a rising edge, idle again.
  task automatic do_op(input logic s, input logic [1:0] vld,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic [2:0] r0, input logic [2:0] r1, input int hold,
                       input logic g, input logic [31:0] res, input logic [7:0] st,
                       input logic [2:0] rnd);
    int mc;
    logic [1:0] oh;
    logic [8:0] ev;
    mc = s ? 1 : 2;
    oh = g ? 2'b10 : 2'b01;
    sel = s;
    req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
    req_rnd0 = r0; req_rnd1 = r1;
    req_valid = vld;
    @(negedge clk);
    chk("grant", {o_busy, o_rr}, {1'b0, oh});
    @(posedge clk); #1;
    // Operands move after accept; the datapath copies must not follow.
    req_a0 = $urandom; req_b0 = $urandom; req_a1 = $urandom; req_b1 = $urandom;
    req_rnd0 = 3'($urandom_range(0, 7)); req_rnd1 = 3'($urandom_range(0, 7));
    for (int c = 1; c <= mc + 4; c++) begin
      @(negedge clk);
      ev = {c <= mc, c == mc + 1, c == mc + 2, c == mc + 3,
            (c == mc + 4) ? oh : 2'b00, 1'b1, 2'b00};
      chk($sformatf("ctl_c%0d", c), {o_men, o_nen, o_ren, o_een, o_rv, o_busy, o_rr}, ev);
      if (c < mc + 4) begin
        @(posedge clk); #1;
      end
    end
    chk("resp", {o_res, o_st}, {res, st});
    chk("dp_hold", {o_dpa, o_dpb, o_dprnd}, {g ? a1 : a0, g ? b1 : b0, rnd});
    for (int h = 0; h < hold; h++) begin
      resp_ready = ~oh;  // the non-owner bit must be ignored
      @(posedge clk); #1;
      @(negedge clk);
      chk("backpressure", {o_rv, o_res, o_st, o_rr}, {oh, res, st, 2'b00});
    end
    resp_ready = oh;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    req_valid  = 2'b00;
    m_cnt[s]   = m_cnt[s] + 16'd1;
    m_lastg[s] = g;
    if (!s) m_lda = g ? a1 : a0;
    @(negedge clk);
    chk("done", {o_busy, o_rv, o_cnt}, {1'b0, 2'b00, m_cnt[s]});
    @(posedge clk); #1;
  endtask

  task automatic rand_op(input logic s, input logic [1:0] vld);
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  r0, r1, r, re;
    logic        g;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    r0 = 3'($urandom_range(0, 7)); r1 = 3'($urandom_range(0, 7));
    g  = (vld == 2'b11) ? ~m_lastg[s] : vld[1];
    r  = g ? r1 : r0;
    re = (r > 3'd5) ? 3'd0 : r;
    do_op(s, vld, a0, b0, a1, b1, r0, r1, $urandom_range(0, 3), g,
          fake_mul(g ? a1 : a0, g ? b1 : b0), {r > 3'd5, 4'b0000, re}, re);
  endtask

  typedef struct {
    logic        s;
    logic [1:0]  vld;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  r0, r1;
    int          hold;
    logic        g;
    logic [31:0] res;
    logic [7:0]  st;
    logic [2:0]  rnd;
  } vec_t;

  vec_t tv [8];

  initial begin
    int k;
    tv[0] = '{1'b0, 2'b01, 32'h3FC00000, 32'h40000000, 32'h0, 32'h0, 3'd0, 3'd0, 0,
              1'b0, 32'h40400000, 8'h00, 3'd0};
    tv[1] = '{1'b0, 2'b10, 32'h0, 32'h0, 32'h40000000, 32'h40000000, 3'd0, 3'd7, 5,
              1'b1, 32'h40800000, 8'h80, 3'd0};
    tv[2] = '{1'b0, 2'b10, 32'h0, 32'h0, 32'h3F800000, 32'hBF800000, 3'd0, 3'd2, 1,
              1'b1, 32'hBF800000, 8'h02, 3'd2};
    tv[3] = '{1'b0, 2'b11, 32'h40400000, 32'h40400000, 32'h3F800000, 32'h40A00000, 3'd5, 3'd4, 0,
              1'b0, 32'h41100000, 8'h05, 3'd5};
    tv[4] = '{1'b0, 2'b11, 32'h40400000, 32'h40400000, 32'h3F800000, 32'h40A00000, 3'd5, 3'd4, 2,
              1'b1, 32'h40A00000, 8'h04, 3'd4};
    tv[5] = '{1'b0, 2'b11, 32'h40400000, 32'h40400000, 32'h3F800000, 32'h40A00000, 3'd5, 3'd4, 0,
              1'b0, 32'h41100000, 8'h05, 3'd5};
    tv[6] = '{1'b0, 2'b11, 32'h40400000, 32'h40400000, 32'h3F800000, 32'h40A00000, 3'd5, 3'd4, 0,
              1'b1, 32'h40A00000, 8'h04, 3'd4};
    tv[7] = '{1'b1, 2'b01, 32'h3FC00000, 32'h40000000, 32'h0, 32'h0, 3'd6, 3'd0, 2,
              1'b0, 32'h40400000, 8'h80, 3'd0};

    m_cnt[0] = 16'd0; m_cnt[1] = 16'd0;
    m_lastg[0] = 1'b1; m_lastg[1] = 1'b1;
    m_lda = 32'd0;
    rst = 1'b0; sel = 1'b0;
    req_valid = 2'b00; resp_ready = 2'b00;
    req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
    req_rnd0 = 3'd0; req_rnd1 = 3'd0;

    // Reset state on both instances
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", {28'd0, all_o}, 160'd0);
    sel = 1'b1; #1;
    chk("reset_b", {28'd0, all_o}, 160'd0);
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed table: single op, illegal mode, contention, MULT_CYCLES=1
    for (int i = 0; i < 8; i++)
      do_op(tv[i].s, tv[i].vld, tv[i].a0, tv[i].b0, tv[i].a1, tv[i].b1,
            tv[i].r0, tv[i].r1, tv[i].hold, tv[i].g, tv[i].res, tv[i].st, tv[i].rnd);

    // Valid withdrawn before the edge: nothing is latched
    sel = 1'b0;
    req_a0 = 32'hDEADBEEF;
    req_valid = 2'b01;
    @(negedge clk);
    chk("drop_ready", o_rr, 2'b01);
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_nolatch", {o_busy, o_dpa}, {1'b0, m_lda});
    @(posedge clk); #1;

    // Randomized traffic on A, a few on B
    for (int i = 0; i < 30; i++) rand_op(1'b0, 2'($urandom_range(1, 3)));
    for (int i = 0; i < 4; i++)  rand_op(1'b1, 2'($urandom_range(1, 3)));

    // op_count wrap on B
    sel = 1'b1;
    force dut_b.op_count_q = 16'hFFFF;
    #1;
    release dut_b.op_count_q;
    m_cnt[1] = 16'hFFFF;
    rand_op(1'b1, 2'b01);

    // Reset during ROUND on A
    sel = 1'b0;
    req_a0 = 32'h3FC00000; req_b0 = 32'h40000000; req_rnd0 = 3'd1;
    req_valid = 2'b01;
    @(posedge clk); #1;
    k = 0;
    while (!o_ren && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("reach_round", o_ren, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("reset_midop", {28'd0, all_o}, 160'd0);
    m_cnt[0] = 16'd0; m_cnt[1] = 16'd0;
    m_lastg[0] = 1'b1; m_lastg[1] = 1'b1;
    m_lda = 32'd0;
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("no_stale", {o_busy, o_rv, o_cnt}, 19'd0);
    end
    @(posedge clk); #1;
    rand_op(1'b0, 2'b10);
    rand_op(1'b0, 2'b11);
    rand_op(1'b0, 2'b11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
